// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM type and sizing helpers for the systolic stream matmul
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, UNLOAD} state_e;
    function automatic int o_bits(input int i_bits, input int k_max);
        return 2 * i_bits + $clog2(k_max);
    endfunction
    function automatic int drain_cycles(input int size);
        return 2 * size - 1;
    endfunction
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: output-stationary MAC cell with a/b pass-through and per-job signedness
module systolic_pe #(
    parameter int I_BITS = 8,
    parameter int O_BITS = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              signed_i,
    input  logic [I_BITS-1:0] a_i,
    input  logic [I_BITS-1:0] b_i,
    output logic [I_BITS-1:0] a_o,
    output logic [I_BITS-1:0] b_o,
    output logic [O_BITS-1:0] acc_o
);
    logic [I_BITS-1:0] a_q, b_q;
    logic [O_BITS-1:0] acc_q, acc_d, a_x, b_x, prod;
    always_comb begin
        a_x   = {{(O_BITS-I_BITS){signed_i & a_i[I_BITS-1]}}, a_i};
        b_x   = {{(O_BITS-I_BITS){signed_i & b_i[I_BITS-1]}}, b_i};
        prod  = a_x * b_x;
        acc_d = clr_i ? prod : acc_q + prod;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/systolic_stream_matmul.sv
// systolic_stream_matmul: streamed SIZExSIZE output-stationary matmul with internal skew and row unload
module systolic_stream_matmul
    import systolic_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int I_BITS = 8,
    parameter int K_MAX  = 8,
    parameter int O_BITS = o_bits(I_BITS, K_MAX)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_signed,
    input  logic [cnt_w(K_MAX)-1:0]  i_k,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [SIZE*I_BITS-1:0]   i_a_full,
    input  logic [SIZE*I_BITS-1:0]   i_b_full,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [SIZE*O_BITS-1:0]   o_c_row,
    output logic [$clog2(SIZE)-1:0]  o_row_idx,
    output logic                     o_out_last,
    output logic                     o_busy
);
    localparam int KW           = cnt_w(K_MAX);
    localparam int RW           = $clog2(SIZE);
    localparam int DRAIN_CYCLES = drain_cycles(SIZE);
    localparam int DW           = cnt_w(DRAIN_CYCLES);

    state_e                 state_q, state_d;
    logic                   signed_q, signed_d, accept, clr, mode;
    logic [KW-1:0]          k_q, k_d, beat_q, beat_d, k_clamp;
    logic [DW-1:0]          drain_q, drain_d;
    logic [RW-1:0]          row_q, row_d, row_sel;
    logic [SIZE*O_BITS-1:0] c_row_q, c_row_d, row_w;
    logic [I_BITS-1:0]      a_h [SIZE][SIZE+1];
    logic [I_BITS-1:0]      b_v [SIZE+1][SIZE];
    logic [O_BITS-1:0]      acc [SIZE][SIZE];

    assign o_in_ready  = !i_reset && (state_q == IDLE || state_q == LOAD);
    assign accept      = i_in_valid && o_in_ready;
    assign clr         = accept && state_q == IDLE;
    assign mode        = state_q == IDLE ? i_signed : signed_q;
    assign k_clamp     = (i_k == '0 || i_k > KW'(K_MAX)) ? KW'(K_MAX) : i_k;
    assign o_out_valid = state_q == UNLOAD;
    assign o_out_last  = o_out_valid && row_q == RW'(SIZE - 1);
    assign o_busy      = state_q != IDLE;
    assign o_row_idx   = row_q;
    assign o_c_row     = c_row_q;

    for (genvar i = 0; i < SIZE; i++) begin : g_skew
        logic [2*I_BITS-1:0] feed;
        assign feed = accept ? {i_a_full[i*I_BITS +: I_BITS], i_b_full[i*I_BITS +: I_BITS]} : '0;
        if (i == 0) begin : g_direct
            assign {a_h[0][0], b_v[0][0]} = feed;
        end else begin : g_delay
            logic [2*I_BITS-1:0] d_q [i];
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    for (int n = 0; n < i; n++) d_q[n] <= '0;
                end else begin
                    d_q[0] <= feed;
                    for (int n = 1; n < i; n++) d_q[n] <= d_q[n-1];
                end
            end
            assign {a_h[i][0], b_v[0][i]} = d_q[i-1];
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            systolic_pe #(.I_BITS(I_BITS), .O_BITS(O_BITS)) u_pe (
                .clk_i   (i_clock),
                .rst_i   (i_reset),
                .clr_i   (clr),
                .signed_i(mode),
                .a_i     (a_h[i][j]),
                .b_i     (b_v[i][j]),
                .a_o     (a_h[i][j+1]),
                .b_o     (b_v[i+1][j]),
                .acc_o   (acc[i][j])
            );
        end
    end

    always_comb begin
        row_w   = '0;
        row_sel = state_q == DRAIN ? '0 : row_q + 1'b1;
        for (int j = 0; j < SIZE; j++) row_w[j*O_BITS +: O_BITS] = acc[row_sel][j];
    end

    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        k_d      = k_q;
        beat_d   = beat_q;
        drain_d  = '0;
        row_d    = row_q;
        c_row_d  = c_row_q;
        case (state_q)
            IDLE: if (accept) begin
                signed_d = i_signed;
                k_d      = k_clamp;
                beat_d   = KW'(1);
                state_d  = k_clamp == KW'(1) ? DRAIN : LOAD;
            end
            LOAD: if (accept) begin
                beat_d  = beat_q + 1'b1;
                state_d = beat_q + 1'b1 == k_q ? DRAIN : LOAD;
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = UNLOAD;
                    row_d   = '0;
                    c_row_d = row_w;
                end
            end
            UNLOAD: if (i_out_ready) begin
                if (o_out_last) state_d = IDLE;
                else begin
                    row_d   = row_q + 1'b1;
                    c_row_d = row_w;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            signed_q <= 1'b0;
            k_q      <= '0;
            beat_q   <= '0;
            drain_q  <= '0;
            row_q    <= '0;
            c_row_q  <= '0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            k_q      <= k_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            row_q    <= row_d;
            c_row_q  <= c_row_d;
        end
    end
endmodule

// File: tb/tb_systolic_stream_matmul.sv
// tb_systolic_stream_matmul: directed self-checking bench for systolic_stream_matmul
module tb_systolic_stream_matmul;
    localparam int SIZE = 8, I_BITS = 8, K_MAX = 8, O_BITS = 19, W = SIZE * O_BITS;

    logic                   clk = 1'b0, i_reset = 1'b1, i_signed = 1'b0;
    logic                   i_in_valid = 1'b0, i_out_ready = 1'b1;
    logic [3:0]             i_k = 4'd8;
    logic [SIZE*I_BITS-1:0] i_a_full = '0, i_b_full = '0;
    logic                   o_in_ready, o_out_valid, o_out_last, o_busy;
    logic [W-1:0]           o_c_row;
    logic [2:0]             o_row_idx;
    int                     checks = 0, failures = 0, cyc = 0, t_first = 0, t_last = 0, lat = 0;
    logic [I_BITS-1:0]      A [SIZE][K_MAX];
    logic [I_BITS-1:0]      B [K_MAX][SIZE];
    logic [W-1:0]           exp_row [SIZE];

    systolic_stream_matmul #(.SIZE(SIZE), .I_BITS(I_BITS), .K_MAX(K_MAX), .O_BITS(O_BITS)) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_signed   (i_signed),
        .i_k        (i_k),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_a_full   (i_a_full),
        .i_b_full   (i_b_full),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_c_row    (o_c_row),
        .o_row_idx  (o_row_idx),
        .o_out_last (o_out_last),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] row;
        logic [31:0]  vv;
        vv = v;
        row = '0;
        for (int j = 0; j < SIZE; j++) row[j*O_BITS +: O_BITS] = vv[O_BITS-1:0];
        return row;
    endfunction

    function automatic int ext(input logic [I_BITS-1:0] x, input bit s);
        int v;
        v = int'(x);
        if (s && x[I_BITS-1]) v -= 256;
        return v;
    endfunction

    function automatic logic [W-1:0] golden(input int r, input int k, input bit s);
        logic [W-1:0] row;
        logic [31:0]  sv;
        int           sum;
        row = '0;
        for (int j = 0; j < SIZE; j++) begin
            sum = 0;
            for (int t = 0; t < k; t++) sum += ext(A[r][t], s) * ext(B[t][j], s);
            sv = sum;
            row[j*O_BITS +: O_BITS] = sv[O_BITS-1:0];
        end
        return row;
    endfunction

    task automatic send_beat(input int t);
        for (int i = 0; i < SIZE; i++) begin
            i_a_full[i*I_BITS +: I_BITS] = A[i][t];
            i_b_full[i*I_BITS +: I_BITS] = B[t][i];
        end
        i_in_valid = 1'b1;
        for (int g = 0; g < 50 && !o_in_ready; g++) begin
            @(posedge clk); #1;
        end
        if (!o_in_ready) chk("in_ready_wait", W'(o_in_ready), W'(1));
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [3:0] kin, input int keff, input bit sgn, input bit gap);
        i_k = kin;
        i_signed = sgn;
        for (int t = 0; t < keff; t++) begin
            send_beat(t);
            if (t == 0) begin
                t_first = cyc - 1;
                i_k = 4'd2;
                i_signed = !sgn;
            end
            t_last = cyc - 1;
            if (gap && t < keff - 1) begin
                @(posedge clk); #1;
            end
        end
        chk("ready_low_drain", W'(o_in_ready), W'(0));
        chk("busy_drain", W'(o_busy), W'(1));
        for (int g = 0; g < 100 && !o_out_valid; g++) begin
            @(posedge clk); #1;
        end
        chk("out_valid_seen", W'(o_out_valid), W'(1));
        lat = cyc - t_last;
    endtask

    task automatic collect(input bit bp);
        int r;
        r = 0;
        for (int n = 0; n < 200 && r < SIZE; n++) begin
            i_out_ready = bp ? (n % 4 == 0 || n % 4 == 3) : 1'b1;
            if (o_out_valid) begin
                chk("row_idx", W'(o_row_idx), W'(r));
                chk("row_data", o_c_row, exp_row[r]);
                chk("row_last", W'(o_out_last), W'(r == SIZE - 1));
                if (i_out_ready) r++;
            end
            @(posedge clk); #1;
        end
        i_out_ready = 1'b1;
        chk("rows_done", W'(r), W'(SIZE));
        chk("valid_drop", W'(o_out_valid), W'(0));
        chk("ready_back", W'(o_in_ready), W'(1));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, W'(o_in_ready), W'(0));
        chk({tag, "_out_valid"}, W'(o_out_valid), W'(0));
        chk({tag, "_c_row"}, o_c_row, W'(0));
        chk({tag, "_row_idx"}, W'(o_row_idx), W'(0));
        chk({tag, "_last"}, W'(o_out_last), W'(0));
        chk({tag, "_busy"}, W'(o_busy), W'(0));
    endtask

    task automatic set_ab(input int a, input int b);
        for (int i = 0; i < SIZE; i++)
            for (int t = 0; t < K_MAX; t++) begin
                A[i][t] = I_BITS'(a);
                B[t][i] = I_BITS'(b);
            end
    endtask

    task automatic set_exp(input int v);
        for (int r = 0; r < SIZE; r++) exp_row[r] = fill(v);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        i_reset = 1'b0;
        #1;
        chk("ready_after_reset", W'(o_in_ready), W'(1));

        for (int i = 0; i < SIZE; i++)
            for (int t = 0; t < K_MAX; t++) begin
                A[i][t] = I_BITS'(i == t);
                B[t][i] = I_BITS'(8 * t + i);
            end
        for (int r = 0; r < SIZE; r++) begin
            exp_row[r] = '0;
            for (int c = 0; c < SIZE; c++) exp_row[r][c*O_BITS +: O_BITS] = O_BITS'(8 * r + c);
        end
        run_job(4'd8, 8, 1'b0, 1'b0);
        chk("first_valid_cycle", W'(cyc - t_first), W'(23));
        chk("identity_latency", W'(lat), W'(16));
        collect(1'b0);

        set_ab(8'hFF, 8'hFF);
        set_exp(8);
        run_job(4'd8, 8, 1'b1, 1'b0);
        collect(1'b0);

        set_exp(520200);
        run_job(4'd8, 8, 1'b0, 1'b0);
        collect(1'b0);

        set_ab(3, 5);
        set_exp(15);
        run_job(4'd1, 1, 1'b0, 1'b0);
        chk("k1_latency", W'(lat), W'(16));
        collect(1'b0);

        set_ab(1, 1);
        set_exp(8);
        run_job(4'd0, 8, 1'b0, 1'b0);
        collect(1'b0);

        for (int i = 0; i < SIZE; i++)
            for (int t = 0; t < K_MAX; t++) begin
                A[i][t] = I_BITS'($urandom_range(0, 255));
                B[t][i] = I_BITS'($urandom_range(0, 255));
            end
        for (int r = 0; r < SIZE; r++) exp_row[r] = golden(r, 5, 1'b1);
        run_job(4'd5, 5, 1'b1, 1'b1);
        chk("gap_latency", W'(lat), W'(16));
        collect(1'b1);

        i_k = 4'd8;
        i_signed = 1'b0;
        for (int t = 0; t < 3; t++) send_beat(t);
        chk("busy_load", W'(o_busy), W'(1));
        i_reset = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("midjob_reset");
        i_reset = 1'b0;
        #1;
        chk("ready_after_abort", W'(o_in_ready), W'(1));

        for (int i = 0; i < SIZE; i++) begin
            A[i][0] = 8'd2;
            A[i][1] = 8'd1;
            B[0][i] = 8'd3;
            B[1][i] = 8'd4;
        end
        set_exp(10);
        run_job(4'd2, 2, 1'b0, 1'b0);
        collect(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/systolic_stream_matmul.md
# systolic_stream_matmul

Parametrised output-stationary SIZE×SIZE systolic matrix multiplier computing C = A·B for A of SIZE×k and B of k×SIZE, with k programmable per job. It supersedes the free-running systolic processor: input skewing is internal, operands arrive as a valid/ready stream of one A-column plus one B-row per beat, signed or unsigned operands are selectable per job, and results leave row by row through a valid/ready output port. It sits between the operand DMA/stream source and the result sink.

## Interface

- SIZE, 8, array dimension (rows = columns), ≥2
- I_BITS, 8, operand width
- K_MAX, 8, maximum inner dimension per job
- O_BITS, 2*I_BITS+$clog2(K_MAX), accumulator and result element width
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_signed  in  1  operand mode (1 = two's complement); sampled on the first accepted beat of a job
- i_k  in  $clog2(K_MAX+1)  inner dimension; sampled on the first accepted beat; 0 or >K_MAX is clamped to K_MAX
- i_in_valid  in  1  operand beat valid
- o_in_ready  out  1  block accepts a beat
- i_a_full  in  SIZE*I_BITS  A column; slice i (bits i*I_BITS +: I_BITS) = A[i][beat]
- i_b_full  in  SIZE*I_BITS  B row; slice j = B[beat][j]
- o_out_valid  out  1  result row valid
- i_out_ready  in  1  sink accepts the row
- o_c_row  out  SIZE*O_BITS  row r of C; slice j = C[r][j]
- o_row_idx  out  $clog2(SIZE)  index r of the presented row
- o_out_last  out  1  high with row SIZE-1
- o_busy  out  1  high in LOAD, DRAIN, UNLOAD

## Operation

- FSM states: IDLE, LOAD, DRAIN, UNLOAD.
- IDLE: o_in_ready=1. First accepted beat (valid&ready) clears all accumulators, latches mode and clamped k, counts as beat 1, moves to LOAD (or straight to DRAIN if k=1).
- LOAD: o_in_ready=1; each accepted beat increments the beat counter; acceptance of beat k moves to DRAIN.
- Bubbles: a cycle without acceptance in IDLE/LOAD/DRAIN feeds zeros into the skew lines; the array shifts every cycle regardless, so bubbles contribute nothing.
- Skew: row i of A is delayed i cycles, column j of B delayed j cycles before entering the array; PE(i,j) forwards a right, b down, accumulates a*b.
- DRAIN: o_in_ready=0; exactly 2*SIZE-1 cycles, then UNLOAD with row 0 loaded.
- UNLOAD: o_in_ready=0; rows 0..SIZE-1 presented in order; row advances only on valid&ready; handshake on row SIZE-1 returns to IDLE.
- Arithmetic: product 2*I_BITS, sign-extended (signed) or zero-extended (unsigned) to O_BITS; accumulation modulo 2^O_BITS (no overflow possible for k≤K_MAX at default O_BITS).
- i_signed / i_k changes after the first beat are ignored until the next job.

## Timing

- Reset values: o_in_ready=0, o_out_valid=0, o_c_row=0, o_row_idx=0, o_out_last=0, o_busy=0; state IDLE, accumulators, skew and PE registers zero. o_in_ready=1 on the first cycle after reset deasserts.
- Reset mid-job: aborts immediately, all state as above; partial results discarded.
- Latency: last beat accepted at edge T → o_out_valid high in cycle T+2*SIZE. Back-to-back k beats from edge 0 → first row at cycle k-1+2*SIZE.
- Output registered; o_c_row, o_row_idx, o_out_last held stable while o_out_valid&!i_out_ready.
- Unload throughput: one row per cycle with i_out_ready held high; o_out_valid drops the cycle after the last handshake, o_in_ready rises the same cycle.
- No overlap between jobs: next job's first beat accepted no earlier than the cycle after the final row handshake.

## Structure

- Package systolic_pkg: state enum, function o_bits(I_BITS,K_MAX), localparam DRAIN_CYCLES = 2*SIZE-1 (as function of SIZE), counter-width helpers.
- Sub-module systolic_pe: one MAC cell (a/b pass-through registers, mode input, clear, O_BITS accumulator); instantiated SIZE×SIZE via generate.
- Top holds FSM, beat/drain/row counters, skew delay lines, output row mux register.

## Test plan

- Unsigned, SIZE=8, k=8, A=identity, B[r][c]=8r+c, back-to-back, out_ready=1 → rows equal B, o_out_valid at cycle 23, o_out_last on row 7.
- Signed, k=8, all A=B=-1 (0xFF) → every C element =8; same data unsigned → every element =8*65025=520200.
- k=1, A column all 3, B row all 5 → all elements 15; k=0 input → treated as 8.
- Random data k=5 with in_valid low every other cycle → results match golden model; latency measured from last accepted beat =2*SIZE.
- Backpressure: i_out_ready toggled 1-0-0-1 pattern → each row presented once, held stable while stalled, rows in order 0..7.
- Reset asserted in LOAD after 3 beats → all outputs zero next cycle, o_in_ready=1 after release, fresh job produces correct results with no residue.
